// File: rtl/methane_mem_pkg.sv
// methane_mem_pkg: shared types and owner-selection helper for mem_arbiter
package methane_mem_pkg;
    typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} arb_owner_t;
    // On contention, round-robin hands the port to whoever did not own it last;
    // otherwise data always beats fetch.
    function automatic arb_owner_t pick_owner(
        input logic       if_req,
        input logic       d_req,
        input logic       rr_en,
        input arb_owner_t last_owner
    );
        return (if_req && d_req) ? ((rr_en && last_owner == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA)
                                 : (d_req ? OWNER_DATA : OWNER_FETCH);
    endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency BRAM port between instruction fetch and data load/store.
//   clk, rst                    : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request -> if_gnt, if_rvalid, if_rdata
//   d_req/d_we/d_addr/d_wdata   : data request  -> d_gnt, d_rvalid, d_rdata
//   mem_en/mem_we/mem_addr/mem_din/mem_dout : BRAM port, read data valid MEM_LATENCY cycles after mem_en
//   busy                        : high while an access is in flight
//   Define MEM_ARB_ROUND_ROBIN_EN to alternate ownership on contention instead of data-first priority.
module mem_arbiter
    import methane_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              busy
);
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_latency_check
        $error("mem_arbiter: MEM_LATENCY must be in 1..15");
    end

    arb_state_t r_state;
    arb_owner_t r_owner;
    logic [3:0] r_cnt;
    arb_owner_t w_pick;
    logic       w_start;
    logic       w_done;
    logic       w_unused;

    // Byte offset and bits above the memory's word range are not used.
    assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_t r_last_owner;
    always_ff @(posedge clk) begin
        if (rst) r_last_owner <= OWNER_DATA;
        else if (w_start) r_last_owner <= w_pick;
    end
    assign w_pick = pick_owner(if_req, d_req, 1'b1, r_last_owner);
`else
    assign w_pick = pick_owner(if_req, d_req, 1'b0, OWNER_DATA);
`endif

    assign w_start = (r_state == ARB_IDLE) && (if_req || d_req);
    // The counter holds through the issue cycle (mem_en high), so it reaches 1
    // exactly when mem_dout carries the read result.
    assign w_done  = (r_state == ARB_ACCESS) && !mem_en && (r_cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWNER_DATA;
            r_cnt     <= 4'd0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 4'd0;
            mem_addr  <= '0;
            mem_din   <= 32'd0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= w_start && (w_pick == OWNER_FETCH);
            d_gnt     <= w_start && (w_pick == OWNER_DATA);
            mem_en    <= w_start;
            if_rvalid <= w_done && (r_owner == OWNER_FETCH);
            d_rvalid  <= w_done && (r_owner == OWNER_DATA);
            if (w_start) begin
                r_state  <= ARB_ACCESS;
                busy     <= 1'b1;
                r_cnt    <= LAT;
                r_owner  <= w_pick;
                mem_we   <= (w_pick == OWNER_DATA) ? d_we : 4'd0;
                mem_addr <= (w_pick == OWNER_DATA) ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
                mem_din  <= (w_pick == OWNER_DATA) ? d_wdata : 32'd0;
            end else begin
                mem_we <= 4'd0;
                if (r_state == ARB_ACCESS && !mem_en) r_cnt <= r_cnt - 4'd1;
            end
            if (w_done) begin
                r_state <= ARB_IDLE;
                busy    <= 1'b0;
            end
            if (w_done && r_owner == OWNER_FETCH) if_rdata <= mem_dout;
            if (w_done && r_owner == OWNER_DATA) d_rdata <= mem_dout;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a BRAM model and rdata scoreboard
module tb_mem_arbiter;
    localparam int L = 2;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] maddr;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, busy;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_din, mem_dout;

    logic        if_req_1, if_gnt_1, if_rvalid_1;
    logic [31:0] if_addr_1, if_rdata_1;
    logic        d_req_1, d_gnt_1, d_rvalid_1;
    logic [3:0]  d_we_1;
    logic [31:0] d_addr_1, d_wdata_1, d_rdata_1;
    logic        mem_en_1, busy_1;
    logic [3:0]  mem_we_1;
    logic [15:0] mem_addr_1;
    logic [31:0] mem_din_1, mem_dout_1;

    mem_arbiter #(.ADDR_W(16), .MEM_LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy)
    );

    mem_arbiter #(.ADDR_W(16), .MEM_LATENCY(1)) u_dut_1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_din(mem_din_1), .mem_dout(mem_dout_1),
        .busy(busy_1)
    );

    wire [121:0] outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                         mem_en, mem_we, mem_addr, mem_din, busy};

    // BRAM model: read data appears L cycles after mem_en, writes commit at the end of the issue cycle.
    logic [31:0] mem [0:255];
    logic [31:0] p0, p1, q0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
        end
        p0 <= mem_en ? mem[mem_addr[7:0]] : 32'h0;
        p1 <= p0;
        q0 <= mem_en_1 ? mem[mem_addr_1[7:0]] : 32'h0;
    end
    assign mem_dout   = p1;
    assign mem_dout_1 = q0;

    int n_vec = 0;
    int n_err = 0;
    exp_t if_q[$];
    exp_t d_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (if_rvalid) begin
            exp_t e;
            if (if_q.size() == 0) chk("if_rvalid_unexpected", 1, 0);
            else begin
                e = if_q.pop_front();
                chk("if_rdata", if_rdata, e.data);
            end
        end
        if (d_rvalid) begin
            exp_t e;
            if (d_q.size() == 0) chk("d_rvalid_unexpected", 1, 0);
            else begin
                e = d_q.pop_front();
                if (e.chk_data) chk("d_rdata", d_rdata, e.data);
            end
        end
    end

    task automatic do_access(input vec_t v);
        int vc;
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            d_q.push_back('{v.we == 4'd0, v.rdata});
        end else begin
            if_req = 1; if_addr = v.addr;
            if_q.push_back('{1'b1, v.rdata});
        end
        step();
        chk("gnt", {if_gnt, d_gnt}, v.is_d ? 2'b01 : 2'b10);
        chk("mem_en", mem_en, 1);
        chk("mem_addr", mem_addr, v.maddr);
        chk("mem_we", mem_we, v.is_d ? v.we : 4'd0);
        chk("mem_din", mem_din, v.is_d ? v.wdata : 32'd0);
        if_req = 0; d_req = 0;
        vc = 0;
        for (int n = 2; n <= 30 && vc == 0; n++) begin
            step();
            if (if_rvalid || d_rvalid) vc = n;
        end
        chk("rvalid_cycle", vc, L + 2);
        chk("rvalid_port", {if_rvalid, d_rvalid}, v.is_d ? 2'b01 : 2'b10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[9];
        int dg, ig, dv, iv, ne, nb, ndg, nig, last, vc, nrv;
        vt[0] = '{1'b0, 4'b0000, 32'h0000_0010, 32'h0,         16'd4,  32'hDEADBEEF};
        vt[1] = '{1'b1, 4'b0011, 32'h0000_0020, 32'h1234ABCD,  16'd8,  32'h0};
        vt[2] = '{1'b1, 4'b0000, 32'h0000_0020, 32'h0,         16'd8,  32'hC0DEABCD};
        vt[3] = '{1'b0, 4'b0000, 32'h0000_0023, 32'h0,         16'd8,  32'hC0DEABCD};
        vt[4] = '{1'b1, 4'b0000, 32'hFFFC_0014, 32'h0,         16'd5,  32'hC0DE0005};
        vt[5] = '{1'b1, 4'b1111, 32'h0000_0040, 32'h55AA33CC,  16'd16, 32'h0};
        vt[6] = '{1'b0, 4'b0000, 32'h0000_0040, 32'h0,         16'd16, 32'h55AA33CC};
        vt[7] = '{1'b1, 4'b1000, 32'h0000_0010, 32'h11223344,  16'd4,  32'h0};
        vt[8] = '{1'b0, 4'b0000, 32'h0000_0012, 32'h0,         16'd4,  32'h11ADBEEF};
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req_1 = 0; if_addr_1 = 0; d_req_1 = 0; d_we_1 = 0; d_addr_1 = 0; d_wdata_1 = 0;
        rst = 1; mem_init = 1;
        step();
        chk("reset_state", outs, 0);
        step();
        rst = 0; mem_init = 0;
        step();
        chk("idle_outputs", outs, 0);

        // MEM_LATENCY=1 instance: fetch at cycle 0 completes at cycle 3.
        if_req_1 = 1; if_addr_1 = 32'h10;
        step();
        chk("lat1_gnt", if_gnt_1, 1);
        if_req_1 = 0;
        vc = 0;
        for (int n = 2; n <= 20 && vc == 0; n++) begin
            step();
            if (if_rvalid_1) vc = n;
        end
        chk("lat1_rvalid_cycle", vc, 3);
        chk("lat1_rdata", if_rdata_1, 32'hDEADBEEF);

        for (int i = 0; i < 9; i++) do_access(vt[i]);

        // Contention: data wins, fetch keeps requesting and is served next.
        d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 0;
        if_req = 1; if_addr = 32'h40;
        d_q.push_back('{1'b1, 32'hC0DEABCD});
        if_q.push_back('{1'b1, 32'h55AA33CC});
        dg = 0; ig = 0; dv = 0; iv = 0;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (d_gnt && dg == 0) dg = n;
            if (if_gnt && ig == 0) ig = n;
            if (d_rvalid && dv == 0) dv = n;
            if (if_rvalid && iv == 0) iv = n;
            if (d_gnt) d_req = 0;
            if (if_gnt) if_req = 0;
        end
        chk("cont_d_gnt", dg, 1);
        chk("cont_d_rvalid", dv, 4);
        chk("cont_if_gnt", ig, 5);
        chk("cont_if_rvalid", iv, 8);

        // Both requests held for 20 cycles.
        d_addr = 32'h40; if_addr = 32'h10;
        d_req = 1; if_req = 1;
        ne = 0; nb = 0; ndg = 0; nig = 0; last = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (d_gnt) d_q.push_back('{1'b1, 32'h55AA33CC});
            if (if_gnt) if_q.push_back('{1'b1, 32'h11ADBEEF});
            if (d_gnt) ndg++;
            if (if_gnt) nig++;
            if (busy) nb++;
            if (mem_en) begin
                ne++;
                if (last != 0) chk("mem_en_gap", n - last, 4);
                last = n;
            end
        end
        d_req = 0; if_req = 0;
        chk("tput_mem_en", ne, 5);
        chk("tput_busy", nb, 15);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("tput_d_gnts", ndg, 3);
        chk("tput_if_gnts", nig, 2);
`else
        chk("tput_d_gnts", ndg, 5);
        chk("tput_if_gnts", nig, 0);
`endif
        step(); step();

        // Reset during a read: the access is dropped without rvalid.
        if_req = 1; if_addr = 32'h10;
        step();
        chk("rst_gnt", if_gnt, 1);
        if_req = 0;
        step();
        rst = 1;
        step();
        chk("rst_outputs", outs, 0);
        rst = 0;
        nrv = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (if_rvalid) nrv++;
        end
        chk("rst_no_rvalid", nrv, 0);
        do_access('{1'b0, 4'b0000, 32'h40, 32'h0, 16'd16, 32'h55AA33CC});

        step(); step();
        chk("if_q_empty", if_q.size(), 0);
        chk("d_q_empty", d_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency BRAM port between instruction fetch and data load/store.
- Sits between the core's fetch and load/store logic and the unified memory.
- Performs per-access req/gnt/rvalid handshakes, sequences each access through a latency counter, and routes read data back to the owning requester.
- Byte-order swapping stays in the core; the arbiter passes data unchanged.

Parameters:
- ADDR_W, 16, word-address width of mem_addr.
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_dout; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch accepted and issued
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  4  byte write enables; 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse: data access issued
- d_rvalid  out  1  one-cycle pulse: access complete; d_rdata valid for reads
- d_rdata  out  32  load word
- mem_en  out  1  memory enable, one cycle per access
- mem_we  out  4  memory byte write enables
- mem_addr  out  ADDR_W  word address, equal to addr[ADDR_W+1:2]
- mem_din  out  32  memory write data
- mem_dout  in  32  memory read data
- busy  out  1  high while in ARB_ACCESS

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state is ARB_IDLE, counter is 0, last_owner is DATA.
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- States: ARB_IDLE and ARB_ACCESS.
- ARB_IDLE, cycle t, at least one request high:
  - Pick the winner.
  - At the edge, load mem_en=1, mem_addr, mem_we (d_we for data, 0 for fetch) and mem_din (d_wdata, else 0).
  - Pulse the winner's gnt.
  - Set cnt=MEM_LATENCY and go to ARB_ACCESS.
  - The issue cycle is t+1.
- ARB_ACCESS:
  - mem_en, mem_we and gnt return to 0 after the issue cycle.
  - cnt decrements each cycle.
  - In the cycle where cnt==1 (issue+MEM_LATENCY), latch mem_dout into the owner's rdata, pulse the owner's rvalid at the next edge, and return to ARB_IDLE.
- Latency: req at cycle 0 gives gnt at cycle 1 and rvalid at cycle MEM_LATENCY+2.
- Throughput: at most one access per MEM_LATENCY+2 cycles. The requester may re-request in its rvalid cycle; that request is granted the cycle after.
- Writes also finish with a d_rvalid pulse. d_rdata then holds mem_dout (don't-care). The write is committed by the memory in the issue cycle.
- Priority (default): data beats fetch when both are requested in the same cycle.
- rdata of each port holds its value until that port's next completion.
- Requests raised while in ARB_ACCESS are ignored until ARB_IDLE. A req withdrawn before gnt has no effect.
- addr[1:0] is ignored: accesses are word-aligned, and sub-word selection is done by the requester via d_we and its own extraction.
- rst mid-access: the in-flight access is dropped, no rvalid is produced, and all outputs are 0 at the next edge. A write already issued is not undone.
- MEM_LATENCY outside 1..15 is an elaboration error via $error.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN
  - Defined: on contention the port that is not last_owner wins. last_owner updates on every grant.
  - Undefined: fixed data-over-fetch priority, and last_owner logic is absent.

Decomposition:
- Package methane_mem_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_ACCESS}
  - enum arb_owner_t {OWNER_FETCH, OWNER_DATA}
  - the pick_owner function
- No sub-module; the block is a single module of about 150-250 lines.

Test Plan:
- Lone fetch, MEM_LATENCY=2, if_addr=0x10, mem word 4 = 0xDEADBEEF -> if_gnt at cycle 1, mem_addr=4, if_rvalid at cycle 4, if_rdata=0xDEADBEEF.
- Store d_we=4'b0011, d_addr=0x20, d_wdata=0x1234ABCD -> mem_en=1, mem_we=0011, mem_addr=8 in cycle 1; d_rvalid at cycle 4; a following read of 0x20 returns the low half updated.
- if_req and d_req both high at cycle 0 -> d_gnt at 1, d_rvalid at 4, if_gnt at 5, if_rvalid at 8. With MEM_ARB_ROUND_ROBIN_EN, back-to-back contention alternates between data and fetch.
- Requests held continuously for 20 cycles -> exactly one mem_en per 4 cycles, never two outstanding accesses, busy high 3 of every 4 cycles.
- rst asserted in cycle 2 of a read -> no rvalid ever appears for that read, all outputs 0 at cycle 3, and a new fetch after reset completes normally.
- MEM_LATENCY=1 with a fetch at cycle 0 -> if_rvalid at cycle 3 with correct data.
